// File: rtl/sprite_pixel_pipeline_if.sv
// Pixel-stream bundle between the region decoder / sprite ROM / palette
// loader (master) and the sprite pixel pipeline (slave).
interface sprite_pixel_pipeline_if;
  logic [4:0]  is_sprite;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [7:0]  bg_R;
  logic [7:0]  bg_G;
  logic [7:0]  bg_B;
  logic        hs_in;
  logic        vs_in;
  logic        blank_n_in;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;

  modport master (
    output is_sprite, DrawX, DrawY, bg_R, bg_G, bg_B,
    output hs_in, vs_in, blank_n_in, rom_data,
    output pal_we, pal_waddr, pal_wdata,
    input  rom_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );

  modport slave (
    input  is_sprite, DrawX, DrawY, bg_R, bg_G, bg_B,
    input  hs_in, vs_in, blank_n_in, rom_data,
    input  pal_we, pal_waddr, pal_wdata,
    output rom_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );
endinterface

// File: rtl/sprite_pixel_pipeline.sv
// Sprite pixel pipeline: sprite ID + DrawX/DrawY -> sprite ROM address,
// texel -> 16-entry writable palette, composited over the background.
// Three-cycle fixed latency for RGB and VGA sidebands, one pixel per clock.
module sprite_pixel_pipeline #(
  parameter int SPR_W = 64,
  parameter int SPR_H = 128
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  sprite_pixel_pipeline_if.slave   bus
);

  // Fixed pipeline depth; the sideband delay line is sized from it.
  localparam int LATENCY = 3;

  localparam logic [9:0] SPR_W_L     = 10'(SPR_W);
  localparam logic [9:0] SPR_H_L     = 10'(SPR_H);
  localparam logic [9:0] ID2_BASE_X  = 10'd64;
  localparam logic [9:0] ID2_HEIGHT  = 10'd96;
  // Sideband bundle {hs, vs, blank_n}; idle value keeps syncs high and blanks.
  localparam logic [2:0] SB_IDLE     = 3'b110;

  // Stage 1 registers
  logic [15:0] rom_addr_q, rom_addr_d;
  logic        valid1_q;
  logic [23:0] bg1_q;
  // Stage 2 registers
  logic [3:0]  texel2_q;
  logic        valid2_q;
  logic [23:0] bg2_q;
  // Stage 3 registers
  logic [23:0] rgb_q, rgb_d;
  // Sideband delay line, one entry per pipeline stage
  logic [2:0]  sb_q [LATENCY];
  // Palette storage (must clear on reset, so kept in flops)
  logic [23:0] pal_q [16];

  logic [9:0]  base_x;
  logic [9:0]  height;
  logic [9:0]  lx;
  logic [9:0]  ly;
  logic [2:0]  slot;
  logic        id_ok;
  logic        pix_valid;

  // Sprite geometry, validity and ROM address for the incoming pixel.
  always_comb begin
    base_x    = (bus.is_sprite == 5'd2) ? ID2_BASE_X : 10'd0;
    height    = (bus.is_sprite == 5'd2) ? ID2_HEIGHT : SPR_H_L;
    lx        = bus.DrawX - base_x;  // wraps large when left of the base, so it fails lx < width
    ly        = bus.DrawY;
    id_ok     = (bus.is_sprite >= 5'd1) && (bus.is_sprite <= 5'd8);
    pix_valid = id_ok && (lx < SPR_W_L) && (ly < height);
    slot      = bus.is_sprite[2:0] - 3'd1;  // ID 8 lands in slot 7
    rom_addr_d = rom_addr_q;
    if (pix_valid) begin
      rom_addr_d = {slot, ly[6:0], lx[5:0]};
    end
  end

  // Stage 1: present the ROM address and carry validity/background forward.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      valid1_q   <= 1'b0;
      bg1_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      valid1_q   <= pix_valid;
      bg1_q      <= {bus.bg_R, bus.bg_G, bus.bg_B};
    end
  end

  // Stage 2: capture the ROM texel that answers the stage-1 address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      texel2_q <= '0;
      valid2_q <= 1'b0;
      bg2_q    <= '0;
    end else begin
      texel2_q <= bus.rom_data;
      valid2_q <= valid1_q;
      bg2_q    <= bg1_q;
    end
  end

  // Stage 3 select: opaque sprite texel over background, forced black when blanked.
  always_comb begin
    rgb_d = bg2_q;
    if (valid2_q && (texel2_q != 4'd0)) begin
      rgb_d = pal_q[texel2_q];
    end
    if (!sb_q[LATENCY-2][0]) begin
      rgb_d = '0;
    end
  end

  // Stage 3: register the final colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // Sideband delay line matching the RGB path.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        sb_q[i] <= SB_IDLE;
      end
    end else begin
      sb_q[0] <= {bus.hs_in, bus.vs_in, bus.blank_n_in};
      for (int i = 1; i < LATENCY; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Palette writes; stage 3 reads the pre-write value on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= '0;
      end
    end else if (bus.pal_we) begin
      pal_q[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.VGA_R       = rgb_q[23:16];
  assign bus.VGA_G       = rgb_q[15:8];
  assign bus.VGA_B       = rgb_q[7:0];
  assign bus.VGA_HS      = sb_q[LATENCY-1][2];
  assign bus.VGA_VS      = sb_q[LATENCY-1][1];
  assign bus.VGA_BLANK_N = sb_q[LATENCY-1][0];

endmodule

// File: tb/tb_sprite_pixel_pipeline.sv
// Self-checking bench for sprite_pixel_pipeline: a pixel-level reference
// model checked every clock, plus directed literal expectations.
module tb_sprite_pixel_pipeline;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sprite_pixel_pipeline_if bus ();

  sprite_pixel_pipeline dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Sprite ROM contents: nibble XOR of the address, with one pinned entry.
  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    if (a == 16'h0083) return 4'd5;
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12];
  endfunction

  // ROM address register is the DUT's rom_addr; data follows it in the same cycle.
  assign bus.rom_data = rom_fn(bus.rom_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        valid;
    logic [15:0] addr;
    logic [3:0]  texel;
    logic [23:0] bg;
    logic        hs;
    logic        vs;
    logic        bl;
  } pix_t;

  pix_t        pipe_q[$];
  logic [23:0] pal_m [16];
  logic [15:0] exp_addr;
  logic [23:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_bl;

  function automatic pix_t idle_pix();
    pix_t p;
    p.valid = 1'b0; p.addr = '0; p.texel = '0; p.bg = '0;
    p.hs = 1'b1; p.vs = 1'b1; p.bl = 1'b0;
    return p;
  endfunction

  // Pixel semantics in plain integer arithmetic.
  function automatic pix_t model_pixel(input int id, input int x, input int y,
                                       input logic [23:0] bg, input logic hs,
                                       input logic vs, input logic bl);
    pix_t p;
    int bx, h, lx, a;
    bx = (id == 2) ? 64 : 0;
    h  = (id == 2) ? 96 : 128;
    lx = x - bx;
    p.valid = (id >= 1) && (id <= 8) && (lx >= 0) && (lx < 64) && (y < h);
    a = p.valid ? ((id - 1) * 8192 + y * 64 + lx) : 0;
    p.addr  = 16'(a);
    p.texel = rom_fn(p.addr);
    p.bg = bg; p.hs = hs; p.vs = vs; p.bl = bl;
    return p;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    pipe_q.push_back(idle_pix());
    pipe_q.push_back(idle_pix());
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    exp_addr = '0; exp_rgb = '0;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_bl = 1'b0;
  endtask

  // Model update on each edge and per-cycle compare of every output.
  initial begin
    pix_t cur, old;
    model_reset();
    forever begin
      @(posedge Clk);
      if (!Reset_n) begin
        model_reset();
      end else begin
        cur = model_pixel(int'(bus.is_sprite), int'(bus.DrawX), int'(bus.DrawY),
                          {bus.bg_R, bus.bg_G, bus.bg_B},
                          bus.hs_in, bus.vs_in, bus.blank_n_in);
        pipe_q.push_back(cur);
        old = pipe_q.pop_front();
        if (!old.bl) exp_rgb = '0;
        else if (old.valid && old.texel != 4'd0) exp_rgb = pal_m[old.texel];
        else exp_rgb = old.bg;
        exp_hs = old.hs; exp_vs = old.vs; exp_bl = old.bl;
        if (cur.valid) exp_addr = cur.addr;
        if (bus.pal_we) pal_m[bus.pal_waddr] = bus.pal_wdata;
      end
      #1;
      check("model_rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
      check("model_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(exp_rgb));
      check("model_hs", 32'(bus.VGA_HS), 32'(exp_hs));
      check("model_vs", 32'(bus.VGA_VS), 32'(exp_vs));
      check("model_blank_n", 32'(bus.VGA_BLANK_N), 32'(exp_bl));
    end
  end

  // ---------------- stimulus ----------------
  task automatic px(input int id, input int x, input int y, input logic [23:0] bg, input logic bl);
    bus.is_sprite = 5'(id);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    {bus.bg_R, bus.bg_G, bus.bg_B} = bg;
    bus.blank_n_in = bl;
    bus.hs_in = 1'b1;
    bus.vs_in = 1'b1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic pal_wr(input int a, input logic [23:0] d);
    bus.pal_we = 1'b1;
    bus.pal_waddr = 4'(a);
    bus.pal_wdata = d;
    tick();
    bus.pal_we = 1'b0;
  endtask

  function automatic logic [31:0] rgb_now();
    return 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B});
  endfunction

  initial begin
    logic [23:0] rnd;
    bus.pal_we = 1'b0; bus.pal_waddr = '0; bus.pal_wdata = '0;
    px(0, 0, 0, 24'h0, 1'b1);

    // Reset state
    tick(); tick(); tick();
    check("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
    check("reset_rgb", rgb_now(), 32'h0);
    check("reset_hs", 32'(bus.VGA_HS), 32'h1);
    check("reset_vs", 32'(bus.VGA_VS), 32'h1);
    check("reset_blank_n", 32'(bus.VGA_BLANK_N), 32'h0);
    Reset_n = 1'b1;

    // 1: palette entry 5, ID 1 at (3,2) -> texel 5
    pal_wr(5, 24'hFF8000);
    px(1, 3, 2, 24'h112233, 1'b1); tick();
    check("t1_rom_addr", 32'(bus.rom_addr), 32'h0083);
    px(0, 0, 0, 24'h0, 1'b1); tick(); tick();
    check("t1_rgb", rgb_now(), 32'hFF8000);
    $display("txn t1: id1 (3,2) rgb=%h", rgb_now());

    // 2: ID 2 offset and height limit
    px(2, 70, 95, 24'h010203, 1'b1); tick();
    check("t2_rom_addr", 32'(bus.rom_addr), 32'h37C6);
    px(2, 70, 96, 24'hAABBCC, 1'b1); tick();
    check("t2_rom_addr_hold", 32'(bus.rom_addr), 32'h37C6);
    px(0, 0, 0, 24'h0, 1'b1); tick(); tick();
    check("t2_bg_rgb", rgb_now(), 32'hAABBCC);
    $display("txn t2: id2 (70,96) rgb=%h", rgb_now());

    // 3: transparent texel and out-of-range ID
    px(8, 14, 0, 24'h123456, 1'b1); tick();
    px(9, 3, 2, 24'h9ABCDE, 1'b1); tick();
    px(0, 0, 0, 24'h0, 1'b1); tick();
    check("t3_transparent", rgb_now(), 32'h123456);
    tick();
    check("t3_id9_bg", rgb_now(), 32'h9ABCDE);
    $display("txn t3: id9 rgb=%h", rgb_now());

    // 4: fill palette, then a 640-pixel line with varied IDs/sidebands
    for (int i = 1; i < 16; i++) pal_wr(i, {8'(i * 16), 8'(255 - i * 10), 8'(i * 7)});
    for (int x = 0; x < 640; x++) begin
      rnd = 24'($urandom);
      px((x / 5) % 12, x, (x * 3) % 140, rnd, (x < 600) ? 1'b1 : 1'b0);
      bus.hs_in = (x >= 608 && x < 620) ? 1'b0 : 1'b1;
      bus.vs_in = (x < 10) ? 1'b0 : 1'b1;
      bus.pal_we = (x % 37 == 0);
      bus.pal_waddr = 4'(x % 16);
      bus.pal_wdata = 24'($urandom);
      tick();
    end
    bus.pal_we = 1'b0;
    px(0, 0, 0, 24'h0, 1'b1); tick(); tick(); tick();
    $display("txn t4: 640-pixel line streamed, checks=%0d", checks);

    // 5: read-before-write on palette entry 5
    pal_wr(5, 24'hFF8000);
    px(1, 3, 2, 24'h0, 1'b1); tick();
    tick();
    px(0, 0, 0, 24'h0, 1'b1);
    bus.pal_we = 1'b1; bus.pal_waddr = 4'd5; bus.pal_wdata = 24'h00FF00;
    tick();
    check("t5_old_colour", rgb_now(), 32'hFF8000);
    bus.pal_we = 1'b0;
    tick();
    check("t5_new_colour", rgb_now(), 32'h00FF00);
    $display("txn t5: old=FF8000 new=%h", rgb_now());

    // 6: asynchronous reset mid-stream
    for (int x = 0; x < 4; x++) begin
      px(1, x, 2, 24'h778899, 1'b1); tick();
    end
    #1;
    Reset_n = 1'b0;
    #1;
    check("t6_async_rgb", rgb_now(), 32'h0);
    check("t6_async_hs", 32'(bus.VGA_HS), 32'h1);
    check("t6_async_vs", 32'(bus.VGA_VS), 32'h1);
    check("t6_async_blank_n", 32'(bus.VGA_BLANK_N), 32'h0);
    check("t6_async_rom_addr", 32'(bus.rom_addr), 32'h0);
    tick(); tick();
    Reset_n = 1'b1;
    px(1, 3, 2, 24'h445566, 1'b1);
    tick();
    check("t6_post_blank1", 32'(bus.VGA_BLANK_N), 32'h0);
    check("t6_post_rgb1", rgb_now(), 32'h0);
    tick();
    check("t6_post_blank2", 32'(bus.VGA_BLANK_N), 32'h0);
    tick();
    check("t6_first_blank_n", 32'(bus.VGA_BLANK_N), 32'h1);
    check("t6_pal_cleared", rgb_now(), 32'h0);
    $display("txn t6: after reset rgb=%h blank_n=%0d", rgb_now(), bus.VGA_BLANK_N);
    px(0, 0, 0, 24'h0, 1'b1); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_pipeline.md
Name: sprite_pixel_pipeline

Overview:
Downstream stage of the sprite region decoder. It consumes the per-pixel sprite ID (is_sprite) together with DrawX/DrawY and fetches the sprite texel from a synchronous sprite ROM. It then resolves the texel through a writable 16-entry palette and composites it over the background colour. The outputs are final VGA RGB, with the sync and blank sidebands delayed to match the pipeline.

Parameters:
LATENCY, 3, fixed pipeline depth in Clk cycles from inputs to outputs; informational, must not be overridden.
SPR_W, 64, sprite width in pixels.
SPR_H, 128, sprite height in pixels (ROM slot height).

Ports:
Clk  in  1  pixel clock.
Reset_n  in  1  asynchronous active-low reset.
is_sprite  in  5  sprite ID from the region decoder; 0 means no sprite.
DrawX  in  10  current pixel X.
DrawY  in  10  current pixel Y.
bg_R, bg_G, bg_B  in  8 each  background colour for this pixel.
hs_in, vs_in, blank_n_in  in  1 each  VGA sidebands aligned with DrawX/DrawY.
rom_addr  out  16  sprite ROM address.
rom_data  in  4  palette index; synchronous ROM, valid one cycle after rom_addr.
pal_we  in  1  palette write enable.
pal_waddr  in  4  palette entry to write.
pal_wdata  in  24  {R,G,B} value to write.
VGA_R, VGA_G, VGA_B  out  8 each  final pixel colour.
VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  sidebands delayed by 3 cycles.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - all pipeline registers clear;
  - rom_addr = 0; VGA_R/G/B = 0;
  - VGA_HS = VGA_VS = 1; VGA_BLANK_N = 0;
  - all palette entries = 24'h000000.
- Release is synchronous to Clk.
- Sprite geometry:
  - ID 2 has base X = 64 (local lx = DrawX - 64) and a valid height of 96 rows.
  - IDs 1 and 3..8 have base X = 0 (lx = DrawX) and a valid height of 128 rows.
  - ly = DrawY for all IDs.
- Validity: a pixel is a sprite pixel only if all of the following hold:
  - ID is in 1..8;
  - lx < 64;
  - ly < valid height.
  Otherwise it is a background pixel. IDs 9..31 are always background.
- Address: rom_addr = {ID-1 [2:0], ly[6:0], lx[5:0]}, i.e. 8 slots of 8192 texels each. For background pixels, rom_addr holds its previous value.
- Stage 1 (edge 1):
  - register rom_addr, the valid flag, bg colour and sidebands.
- Stage 2 (edge 2):
  - rom_data is valid; register the texel index, valid flag, bg colour and sidebands.
- Stage 3 (edge 3) output select:
  - if valid and texel != 0, output palette[texel];
  - else (transparent or invalid) output bg;
  - if the delayed blank_n is 0, force RGB = 0.
- Latency is exactly 3 cycles for RGB and all sidebands. Throughput is one pixel per cycle with no stalls.
- Palette:
  - a write on edge N is visible to stage-3 lookups from edge N+1;
  - a lookup of the same entry on edge N uses the old value (read-before-write);
  - entry 0 is writable but never displayed, because index 0 is always transparent.
- Reset asserted mid-line: outputs go to reset values immediately. The first 3 cycles after release output RGB = 0 with blank_n = 0.
- No state is held across frames other than the palette.

Test Plan:
1. Reset, then pal_we writing entry 5 = 24'hFF8000. Drive ID = 1, DrawX = 3, DrawY = 2 with the ROM model returning 5 -> rom_addr = 16'h0083 one cycle after the inputs; VGA_RGB = FF,80,00 three cycles after the inputs.
2. ID = 2, DrawX = 70, DrawY = 95 -> rom_addr = {3'd1, 7'd95, 6'd6} = 16'h37C6. Same ID with DrawY = 96 -> background colour output, rom_addr unchanged.
3. ID = 8, texel = 0, bg = 12,34,56 -> output 12,34,56 three cycles later. ID = 9 with any texel -> bg output.
4. Stream 640 consecutive pixels with varied IDs against a reference model -> every output matches the model with 3-cycle alignment; HS/VS/BLANK_N are exact 3-cycle delays.
5. pal_we on entry 5 in the same cycle stage 3 reads entry 5 -> old colour on that pixel, new colour on the next pixel.
6. Assert Reset_n low mid-stream, asynchronously between edges -> RGB = 0, HS = VS = 1, BLANK_N = 0 immediately. After release, the first 3 outputs are blanked and the palette reads as 0.
